// File: rtl/avalon_pio_poller_pkg.sv
// Shared types and default constants for the Avalon-MM PIO poller.
package avalon_pio_poller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CMP  = 2'd3
  } state_t;

  localparam int DEF_POLL_DIV     = 50000;
  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_STABLE_N     = 2;
  localparam int AVM_ADDR_W       = 2;
  localparam int AVM_DATA_W       = 32;

endpackage

// File: rtl/avalon_pio_poller_if.sv
// Avalon-MM read-only bus between the poller (master) and a PIO responder (slave).
interface avalon_pio_poller_if;
  import avalon_pio_poller_pkg::*;

  // A read is accepted on the cycle where avm_read=1 and avm_waitrequest=0;
  // avm_readdata is valid a fixed READ_LATENCY cycles after that cycle.
  logic [AVM_ADDR_W-1:0] avm_address;
  logic                  avm_read;
  logic                  avm_waitrequest;
  logic [AVM_DATA_W-1:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/avalon_pio_poller_poll_timer.sv
// Down-counter with load, count enable and zero flag; it holds at zero.
module poll_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= load_val_i;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/avalon_pio_poller.sv
// Periodically reads a PIO responder at offset 0 and publishes a debounced value with a change strobe.
module avalon_pio_poller
  import avalon_pio_poller_pkg::*;
#(
  parameter int VALUE_W      = 8,
  parameter int POLL_DIV     = DEF_POLL_DIV,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int STABLE_N     = DEF_STABLE_N
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               poll_now,
  avalon_pio_poller_if.master avm,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  output logic               change,
  output logic [VALUE_W-1:0] changed_bits,
  output logic               busy,
  output state_t             dbg_state_o
);

  localparam int         TIMER_W    = $clog2(POLL_DIV);
  localparam logic [3:0] STABLE_N_W = 4'(STABLE_N);
  localparam logic [1:0] LAT_INIT   = 2'(READ_LATENCY - 1);

  state_t             state_q, state_d;
  logic [1:0]         lat_cnt_q, lat_cnt_d;
  logic               pending_q, pending_d;
  logic [VALUE_W-1:0] sample_q, sample_d;
  logic [VALUE_W-1:0] cand_q, cand_d;
  logic [3:0]         cnt_q, cnt_d, cnt_upd;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               valid_q, valid_d;
  logic               change_q, change_d;
  logic [VALUE_W-1:0] cb_q, cb_d;

  logic               timer_load, timer_en, timer_zero, start_poll;
  logic [TIMER_W-1:0] unused_timer_count;
  logic               unused_readdata_hi;

  poll_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_val_i (TIMER_W'(POLL_DIV - 1)),
    .load_i     (timer_load),
    .en_i       (timer_en),
    .count_o    (unused_timer_count),
    .zero_o     (timer_zero)
  );

  assign start_poll = poll_now || pending_q || (enable && timer_zero);

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    pending_d  = pending_q;
    sample_d   = sample_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    cnt_upd    = cnt_q;
    value_d    = value_q;
    valid_d    = valid_q;
    change_d   = 1'b0;
    cb_d       = '0;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    // Only one deferred poll is remembered; further requests collapse into it.
    if ((state_q != ST_IDLE) && poll_now) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        timer_en = enable;
        if (start_poll) begin
          state_d    = ST_REQ;
          timer_load = 1'b1;
          pending_d  = 1'b0;
        end
      end
      ST_REQ: begin
        if (!avm.avm_waitrequest) begin
          state_d   = ST_WAIT;
          lat_cnt_d = LAT_INIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          sample_d = avm.avm_readdata[VALUE_W-1:0];
          state_d  = ST_CMP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ST_CMP: begin
        if (sample_q == cand_q) begin
          cnt_upd = (cnt_q >= STABLE_N_W) ? STABLE_N_W : cnt_q + 4'd1;
        end else begin
          cand_d  = sample_q;
          cnt_upd = 4'd1;
        end
        cnt_d = cnt_upd;
        if ((cnt_upd >= STABLE_N_W) && ((sample_q != value_q) || !valid_q)) begin
          value_d  = sample_q;
          valid_d  = 1'b1;
          change_d = 1'b1;
          cb_d     = value_q ^ sample_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      pending_q <= 1'b0;
      sample_q  <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      change_q  <= 1'b0;
      cb_q      <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      pending_q <= pending_d;
      sample_q  <= sample_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      change_q  <= change_d;
      cb_q      <= cb_d;
    end
  end

  // Bus outputs decode the state register only, so no input reaches an output combinationally.
  assign avm.avm_address = '0;
  assign avm.avm_read    = (state_q == ST_REQ);
  assign busy            = (state_q != ST_IDLE);
  assign value           = value_q;
  assign value_valid     = valid_q;
  assign change          = change_q;
  assign changed_bits    = cb_q;
  assign dbg_state_o     = state_q;

  assign unused_readdata_hi = ^avm.avm_readdata[AVM_DATA_W-1:VALUE_W];

endmodule

// File: tb/tb_avalon_pio_poller.sv
// Directed bench for avalon_pio_poller with POLL_DIV=8, READ_LATENCY=1, STABLE_N=2.
module tb_avalon_pio_poller;
  import avalon_pio_poller_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        poll_now = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic [7:0]  value, changed_bits;
  logic        value_valid, change, busy;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;

  avalon_pio_poller_if avm_bus();
  assign avm_bus.avm_waitrequest = wr;
  assign avm_bus.avm_readdata    = resp_data;

  always #5 clk = ~clk;

  avalon_pio_poller #(
    .VALUE_W(8), .POLL_DIV(8), .READ_LATENCY(1), .STABLE_N(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .poll_now     (poll_now),
    .avm          (avm_bus),
    .value        (value),
    .value_valid  (value_valid),
    .change       (change),
    .changed_bits (changed_bits),
    .busy         (busy),
    .dbg_state_o  (dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 400000");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives the responder data, waits for the next read and returns at the first idle cycle.
  task automatic poll_once(input logic [31:0] data, output logic ch, output logic [7:0] cb,
                           output int wc);
    int n;
    resp_data = data;
    wc = 0;
    while (!avm_bus.avm_read && wc < 40) begin
      tick();
      wc++;
    end
    n = 0;
    while (avm_bus.avm_read && busy && n < 20) begin
      tick();
      n++;
    end
    while (busy && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (wc >= 40 || n >= 20) begin
      failures++;
      $display("FAIL poll_timeout: wait=%0d busy_cycles=%0d, required wait<40 busy<20", wc, n);
    end
    ch = change;
    cb = changed_bits;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0;
    tick(); tick();
    checks++; if (avm_bus.avm_read !== 1'b0) begin failures++; $display("FAIL rst_read: got %b required 0", avm_bus.avm_read); end
    checks++; if (avm_bus.avm_address !== 2'b00) begin failures++; $display("FAIL rst_addr: got %b required 00", avm_bus.avm_address); end
    checks++; if (value !== 8'h00) begin failures++; $display("FAIL rst_value: got %h required 00", value); end
    checks++; if (value_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", value_valid); end
    checks++; if (change !== 1'b0) begin failures++; $display("FAIL rst_change: got %b required 0", change); end
    checks++; if (changed_bits !== 8'h00) begin failures++; $display("FAIL rst_cbits: got %h required 00", changed_bits); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
  endtask

  task automatic test_first_poll;
    logic ch; logic [7:0] cb; int wc;
    enable = 1'b1; wr = 1'b0;
    reset = 1'b0;
    poll_once(32'hFFFF_FF5A, ch, cb, wc);
    checks++; if (wc !== 8) begin failures++; $display("FAIL first_read_delay: got %0d required 8", wc); end
    checks++; if (ch !== 1'b0) begin failures++; $display("FAIL first_poll_change: got %b required 0", ch); end
    checks++; if (value_valid !== 1'b0) begin failures++; $display("FAIL first_poll_valid: got %b required 0", value_valid); end
    poll_once(32'h1234_005A, ch, cb, wc);
    checks++; if (wc !== 8) begin failures++; $display("FAIL poll_period: got %0d required 8", wc); end
    checks++; if (ch !== 1'b1) begin failures++; $display("FAIL accept_change: got %b required 1", ch); end
    checks++; if (cb !== 8'h5A) begin failures++; $display("FAIL accept_cbits: got %h required 5a", cb); end
    checks++; if (value !== 8'h5A) begin failures++; $display("FAIL accept_value: got %h required 5a", value); end
    checks++; if (value_valid !== 1'b1) begin failures++; $display("FAIL accept_valid: got %b required 1", value_valid); end
    tick();
    checks++; if (change !== 1'b0 || changed_bits !== 8'h00) begin failures++; $display("FAIL change_one_cycle: got change=%b cbits=%h required 0/00", change, changed_bits); end
  endtask

  task automatic test_glitch;
    logic ch; logic [7:0] cb; int wc;
    poll_once(32'h0000_003C, ch, cb, wc);
    checks++; if (ch !== 1'b0) begin failures++; $display("FAIL glitch_change1: got %b required 0", ch); end
    poll_once(32'h0000_005A, ch, cb, wc);
    checks++; if (ch !== 1'b0) begin failures++; $display("FAIL glitch_change2: got %b required 0", ch); end
    checks++; if (value !== 8'h5A) begin failures++; $display("FAIL glitch_value: got %h required 5a", value); end
  endtask

  task automatic test_change;
    logic ch; logic [7:0] cb; int wc;
    poll_once(32'h0000_003C, ch, cb, wc);
    checks++; if (ch !== 1'b0) begin failures++; $display("FAIL chg_first_read: got %b required 0", ch); end
    poll_once(32'h0000_003C, ch, cb, wc);
    checks++; if (ch !== 1'b1) begin failures++; $display("FAIL chg_second_read: got %b required 1", ch); end
    checks++; if (cb !== 8'h66) begin failures++; $display("FAIL chg_cbits: got %h required 66", cb); end
    checks++; if (value !== 8'h3C) begin failures++; $display("FAIL chg_value: got %h required 3c", value); end
    tick();
    checks++; if (change !== 1'b0) begin failures++; $display("FAIL chg_pulse_width: got %b required 0", change); end
    poll_once(32'h0000_003C, ch, cb, wc);
    checks++; if (ch !== 1'b0) begin failures++; $display("FAIL chg_single_pulse: got %b required 0", ch); end
  endtask

  task automatic test_waitrequest;
    logic ch; logic [7:0] cb; int wc; int n; int bad;
    wr = 1'b1;
    resp_data = 32'h0000_00FF;
    n = 0;
    while (!avm_bus.avm_read && n < 40) begin
      tick();
      n++;
    end
    checks++; if (avm_bus.avm_read !== 1'b1) begin failures++; $display("FAIL wr_read_start: got %b required 1", avm_bus.avm_read); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (avm_bus.avm_read !== 1'b1 || avm_bus.avm_address !== 2'b00) bad++;
      if (i < 4) tick();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL wr_stall_hold: got %0d bad cycles required 0", bad); end
    wr = 1'b0;
    tick();
    resp_data = 32'h0000_0081;
    checks++; if (avm_bus.avm_read !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL wr_read_drop: got read=%b busy=%b required 0/1", avm_bus.avm_read, busy); end
    tick(); tick();
    checks++; if (busy !== 1'b0 || change !== 1'b0) begin failures++; $display("FAIL wr_txn_end: got busy=%b change=%b required 0/0", busy, change); end
    poll_once(32'h0000_0081, ch, cb, wc);
    checks++; if (ch !== 1'b1 || cb !== 8'hBD) begin failures++; $display("FAIL wr_sample_point: got change=%b cbits=%h required 1/bd", ch, cb); end
    checks++; if (value !== 8'h81) begin failures++; $display("FAIL wr_value: got %h required 81", value); end
  endtask

  task automatic test_poll_now;
    int rises; logic prev;
    enable = 1'b0;
    tick(); tick(); tick();
    checks++; if (avm_bus.avm_read !== 1'b0) begin failures++; $display("FAIL pn_timer_gated: got %b required 0", avm_bus.avm_read); end
    wr = 1'b1;
    poll_now = 1'b1; tick(); poll_now = 1'b0;
    checks++; if (avm_bus.avm_read !== 1'b1) begin failures++; $display("FAIL pn_start: got %b required 1", avm_bus.avm_read); end
    tick();
    poll_now = 1'b1; tick(); poll_now = 1'b0;
    tick();
    poll_now = 1'b1; tick(); poll_now = 1'b0;
    wr = 1'b0;
    rises = 0;
    prev = avm_bus.avm_read;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (avm_bus.avm_read && !prev) rises++;
      prev = avm_bus.avm_read;
    end
    checks++; if (rises !== 1) begin failures++; $display("FAIL pn_txn_count: got %0d extra reads required 1", rises); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pn_idle_after: got busy=%b required 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic ch; logic [7:0] cb; int wc; int n;
    enable = 1'b1; wr = 1'b0;
    resp_data = 32'h0000_00FF;
    n = 0;
    while (!avm_bus.avm_read && n < 40) begin
      tick();
      n++;
    end
    tick();
    checks++; if (dbg_state !== ST_WAIT) begin failures++; $display("FAIL rm_in_wait: got %0d required 2", dbg_state); end
    reset = 1'b1;
    tick();
    checks++; if (avm_bus.avm_read !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rm_read: got read=%b busy=%b required 0/0", avm_bus.avm_read, busy); end
    checks++; if (value !== 8'h00 || value_valid !== 1'b0 || change !== 1'b0) begin failures++; $display("FAIL rm_outputs: got value=%h valid=%b change=%b required 00/0/0", value, value_valid, change); end
    reset = 1'b0;
    poll_once(32'h0000_00FF, ch, cb, wc);
    checks++; if (wc !== 8 || ch !== 1'b0) begin failures++; $display("FAIL rm_resume_first: got wait=%0d change=%b required 8/0", wc, ch); end
    poll_once(32'h0000_00FF, ch, cb, wc);
    checks++; if (ch !== 1'b1 || cb !== 8'hFF || value !== 8'hFF || value_valid !== 1'b1) begin
      failures++;
      $display("FAIL rm_resume_accept: got change=%b cbits=%h value=%h valid=%b required 1/ff/ff/1", ch, cb, value, value_valid);
    end
  endtask

  initial begin
    test_reset();
    test_first_poll();
    test_glitch();
    test_change();
    test_waitrequest();
    test_poll_now();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_pio_poller.md
Name: avalon_pio_poller

Overview:
Avalon-MM read initiator that periodically polls an input-PIO responder (switch/button ports) at register offset 0. It debounces the sampled value across consecutive polls and emits the stable value with a one-cycle change strobe. It sits beside the Nios II bus and feeds hardware consumers (LED mirror, interrupt logic) without any CPU involvement.

Parameters:
VALUE_W, 8, width of sampled field, taken from avm_readdata[VALUE_W-1:0]
POLL_DIV, 50000, clock cycles between poll starts; legal range >= 4
READ_LATENCY, 1, fixed cycles from accepted read to valid readdata; legal range 1..4
STABLE_N, 2, consecutive identical reads required before a new value is accepted; legal range 1..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  periodic polling enabled
poll_now  in  1  one-cycle request for an immediate poll
avm_address  out  2  always 0
avm_read  out  1  read request
avm_waitrequest  in  1  responder stall
avm_readdata  in  32  responder read data
value  out  VALUE_W  debounced stable value
value_valid  out  1  high once the first value has been accepted
change  out  1  one-cycle pulse when value updates
changed_bits  out  VALUE_W  old XOR new, valid with change, otherwise 0
busy  out  1  high in REQ/WAIT/CMP

Behaviour:
- Reset (clk edge with reset=1): state IDLE; avm_read=0, value=0, value_valid=0, change=0, changed_bits=0, busy=0; timer loaded with POLL_DIV-1; candidate=0; stable_cnt=0; pending=0.
- avm_address is constant 0. Outputs are registered, with no combinational path from inputs to outputs.
- IDLE: while enable=1, the timer decrements each cycle. At timer==0, or on poll_now/pending, go to REQ, reload the timer, and clear pending. While enable=0 the timer holds its value. poll_now works regardless of enable.
- REQ: avm_read=1, held until a cycle with avm_waitrequest=0 (acceptance). That cycle drops avm_read next cycle and goes to WAIT with lat_cnt=READ_LATENCY-1.
- WAIT: sample avm_readdata on the cycle exactly READ_LATENCY cycles after acceptance. For latency 1, this is the cycle immediately after acceptance. Then go to CMP.
- CMP (1 cycle), with sample s:
  - If s==candidate: stable_cnt saturates at STABLE_N.
  - Otherwise: candidate=s, stable_cnt=1.
  - If stable_cnt (after update) >= STABLE_N and (s!=value or value_valid=0): value<=s, value_valid<=1, changed_bits<=value^s, change<=1 for the following cycle only.
  - The first acceptance after reset pulses change with changed_bits=s^0.
  - Return to IDLE.
- poll_now while busy sets pending. At most one pending poll is kept; extra requests are dropped.
- Deasserting enable mid-transaction: the transaction completes normally. Only the timer is gated.
- Timer expiry while busy: the timer keeps running only in IDLE, so no poll is lost or doubled.
- Worst-case poll period = POLL_DIV + transaction length. With no waitrequest and latency 1, the transaction is 3 cycles (REQ, WAIT, CMP).
- Reset mid-operation: avm_read is 0 in the cycle after the reset edge, and any in-flight readdata is ignored.
- STABLE_N=1: every differing read updates value immediately.
- Bits of readdata above VALUE_W are ignored.

Decomposition:
- Package avalon_pio_poller_pkg holds the state enum (IDLE, REQ, WAIT, CMP) and the default constants for POLL_DIV, READ_LATENCY and STABLE_N.
- One sub-module, poll_timer: a down-counter with load, enable and zero flag, reusable for other periodic initiators.
- Debounce and compare stay in the top module.

Test Plan:
- Reset, then enable=1, POLL_DIV=8, responder returns 0x5A with waitrequest=0 -> first avm_read 8 cycles after reset release. With STABLE_N=2, change pulses after the 2nd poll: value=0x5A, changed_bits=0x5A, value_valid=1.
- Stable 0x5A, responder switches to 0x3C for one poll then back to 0x5A -> no change pulse; value stays 0x5A.
- Responder switches to 0x3C permanently -> change after the 2nd 0x3C poll with changed_bits=0x66; only one pulse.
- avm_waitrequest held high 5 cycles during REQ -> avm_read stays 1 and address stays 0 all 5 cycles. Data is sampled READ_LATENCY cycles after the release cycle; data presented before that is ignored.
- enable=0, poll_now pulsed twice while busy -> exactly two transactions: the current one plus one pending. A third poll_now during the pending-set window is dropped.
- Reset asserted during WAIT with readdata=0xFF -> value=0, value_valid=0, change=0, avm_read=0 on the next cycle; normal polling resumes after release.
